// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect path: the branch packet exchanged
// between fetch/execute and the redirect controller FSM encoding.
package fetch_redirect_ctrl_pkg;

   localparam int JMP_PC_W = 32;

   // Branch packet: valid = branch seen, en = taken, pc_dst = target
   typedef struct packed {
      logic                valid;
      logic                en;
      logic [JMP_PC_W-1:0] pc_dst;
   } jmp_pack_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_SLOT = 2'd1,
      PENDING   = 2'd2
   } redirect_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl_perf_counter.sv
// Wrapping event counter used for branch statistics.
module jmp_perf_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_inc,
   input  logic                 i_clear,
   output logic [CNT_WIDTH-1:0] o_count
);

   logic [CNT_WIDTH-1:0] r_cnt;

   // Count events; wraps naturally modulo 2^CNT_WIDTH
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)      r_cnt <= '0;
      else if (i_clear) r_cnt <= '0;
      else if (i_inc)   r_cnt <= r_cnt + CNT_WIDTH'(1);
   end

   assign o_count = r_cnt;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Consumes resolved branches from execute, waits for the delay slot,
// redirects the fetch PC with a handshake, flushes the wrong path and
// keeps taken / not-taken statistics.
module fetch_redirect_ctrl
   import fetch_redirect_ctrl_pkg::*;
#(
   parameter int                  PC_WIDTH  = 32,
   parameter int                  CNT_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'hbfc0_0000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 res_valid,
   input  jmp_pack_t            res_jmp,
   output logic                 res_ready,
   input  logic                 slot_fetched,
   output logic                 redirect_valid,
   output logic [PC_WIDTH-1:0]  redirect_pc,
   input  logic                 fetch_ready,
   output logic                 flush,
   output logic                 adel,
   input  logic                 exc_flush,
   output logic [CNT_WIDTH-1:0] taken_cnt,
   output logic [CNT_WIDTH-1:0] ntaken_cnt
);

   redirect_state_t     r_state, w_next;
   logic [PC_WIDTH-1:0] r_target;
   logic [PC_WIDTH-1:0] r_redirect_pc;
   logic [PC_WIDTH-1:0] w_load_val;
   logic                r_flush, r_adel;
   logic                w_accept, w_load_pc, w_hs, w_nt_inc;
   logic [PC_WIDTH-1:0] w_pc_in;

   // A beat arriving together with an exception flush is dropped outright
   assign w_accept = res_valid & res_ready & res_jmp.valid & ~exc_flush;
   assign w_pc_in  = res_jmp.pc_dst[PC_WIDTH-1:0];

   // Next state; redirect_pc only reloads on entry to PENDING so it stays
   // put while no redirect is being requested
   always_comb begin
      w_next     = r_state;
      w_load_pc  = 1'b0;
      w_load_val = r_target;
      w_hs       = 1'b0;
      w_nt_inc   = 1'b0;
      if (exc_flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (!res_jmp.en) begin
                     w_nt_inc = 1'b1;
                  end else if (slot_fetched) begin
                     w_next     = PENDING;
                     w_load_pc  = 1'b1;
                     w_load_val = w_pc_in;
                  end else begin
                     w_next = WAIT_SLOT;
                  end
               end
            end
            WAIT_SLOT: begin
               if (slot_fetched) begin
                  w_next    = PENDING;
                  w_load_pc = 1'b1;
               end
            end
            PENDING: begin
               if (fetch_ready) begin
                  w_hs   = 1'b1;
                  w_next = IDLE;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   // State, target and registered pulse outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= IDLE;
         r_target      <= RESET_PC;
         r_redirect_pc <= RESET_PC;
         r_flush       <= 1'b0;
         r_adel        <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept && res_jmp.en) r_target <= w_pc_in;
         if (w_load_pc) r_redirect_pc <= w_load_val;
         r_flush <= w_hs;
         r_adel  <= w_hs & (|r_redirect_pc[1:0]);
      end
   end

   assign res_ready      = (r_state == IDLE);
   assign redirect_valid = (r_state == PENDING);
   assign redirect_pc    = r_redirect_pc;
   assign flush          = r_flush;
   assign adel           = r_adel;

   jmp_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_taken_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .i_inc   (w_hs),
      .i_clear (1'b0),
      .o_count (taken_cnt)
   );

   jmp_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ntaken_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .i_inc   (w_nt_inc),
      .i_clear (1'b0),
      .o_count (ntaken_cnt)
   );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: redirect latency, delay-slot
// wait, fetch backpressure, misaligned target, exception flush, async
// reset and counter wrap.
module tb_fetch_redirect_ctrl;
   import fetch_redirect_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        res_valid;
   jmp_pack_t   res_jmp;
   logic        res_ready;
   logic        slot_fetched;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_ready;
   logic        flush;
   logic        adel;
   logic        exc_flush;
   logic [15:0] taken_cnt;
   logic [15:0] ntaken_cnt;

   int tests = 0;
   int fails = 0;

   fetch_redirect_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .res_valid      (res_valid),
      .res_jmp        (res_jmp),
      .res_ready      (res_ready),
      .slot_fetched   (slot_fetched),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_ready    (fetch_ready),
      .flush          (flush),
      .adel           (adel),
      .exc_flush      (exc_flush),
      .taken_cnt      (taken_cnt),
      .ntaken_cnt     (ntaken_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic v, input logic jv, input logic en, input logic [31:0] pc);
      res_valid = v;
      res_jmp   = '{valid: jv, en: en, pc_dst: pc};
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdy"},   32'(res_ready),      32'd1);
      chk({tag, "_rv"},    32'(redirect_valid), 32'd0);
      chk({tag, "_pc"},    redirect_pc,         32'hbfc0_0000);
      chk({tag, "_flush"}, 32'(flush),          32'd0);
      chk({tag, "_adel"},  32'(adel),           32'd0);
      chk({tag, "_tc"},    32'(taken_cnt),      32'd0);
      chk({tag, "_ntc"},   32'(ntaken_cnt),     32'd0);
   endtask

   initial begin
      resetn = 1'b0;
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      fetch_ready  = 1'b0;
      exc_flush    = 1'b0;
      #12;
      chk_reset_vals("rst");
      #1 resetn = 1'b1;
      tick();
      tick();

      // taken, slot fetched same cycle, fetch ready at once
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0100);
      slot_fetched = 1'b1;
      fetch_ready  = 1'b1;
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      chk("t1_rv",  32'(redirect_valid), 32'd1);
      chk("t1_pc",  redirect_pc,         32'h8000_0100);
      chk("t1_rdy", 32'(res_ready),      32'd0);
      chk("t1_fl0", 32'(flush),          32'd0);
      tick();
      chk("t1_rv_off", 32'(redirect_valid), 32'd0);
      chk("t1_flush",  32'(flush),          32'd1);
      chk("t1_adel",   32'(adel),           32'd0);
      chk("t1_tc",     32'(taken_cnt),      32'd1);
      tick();
      chk("t1_fl_pulse", 32'(flush), 32'd0);

      // taken, delay slot 3 cycles late, then 4 cycles of fetch backpressure
      fetch_ready = 1'b0;
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0100);
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("t2_ws_rdy", 32'(res_ready),      32'd0);
         chk("t2_ws_rv",  32'(redirect_valid), 32'd0);
         if (i == 2) slot_fetched = 1'b1;
         tick();
      end
      slot_fetched = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t2_pd_rv", 32'(redirect_valid), 32'd1);
         chk("t2_pd_pc", redirect_pc,         32'h8000_0100);
         chk("t2_pd_fl", 32'(flush),          32'd0);
         tick();
      end
      chk("t2_c5_rv", 32'(redirect_valid), 32'd1);
      fetch_ready = 1'b1;
      tick();
      chk("t2_flush", 32'(flush),          32'd1);
      chk("t2_rv",    32'(redirect_valid), 32'd0);
      chk("t2_tc",    32'(taken_cnt),      32'd2);
      tick();
      chk("t2_fl_pulse", 32'(flush), 32'd0);

      // three not-taken back-to-back, then an ignored beat
      beat(1'b1, 1'b1, 1'b0, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_rv",  32'(redirect_valid), 32'd0);
         chk("t3_rdy", 32'(res_ready),      32'd1);
      end
      chk("t3_ntc", 32'(ntaken_cnt), 32'd3);
      beat(1'b1, 1'b0, 1'b1, 32'h8000_0500);
      slot_fetched = 1'b1;
      tick();
      chk("t3_ign_rv",  32'(redirect_valid), 32'd0);
      chk("t3_ign_rdy", 32'(res_ready),      32'd1);
      chk("t3_ign_ntc", 32'(ntaken_cnt),     32'd3);

      // misaligned target: adel pulses alongside flush
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0102);
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      chk("t3_pc", redirect_pc, 32'h8000_0102);
      tick();
      chk("t3_flush", 32'(flush),     32'd1);
      chk("t3_adel",  32'(adel),      32'd1);
      chk("t3_tc",    32'(taken_cnt), 32'd3);
      tick();
      chk("t3_adel_pulse", 32'(adel), 32'd0);

      // exception during WAIT_SLOT
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0200);
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t4_ws_rdy", 32'(res_ready), 32'd0);
      exc_flush = 1'b1;
      tick();
      exc_flush = 1'b0;
      chk("t4_ws_idle", 32'(res_ready),      32'd1);
      chk("t4_ws_rv",   32'(redirect_valid), 32'd0);
      slot_fetched = 1'b1;
      tick();
      slot_fetched = 1'b0;
      chk("t4_ws_fl", 32'(flush),          32'd0);
      chk("t4_ws_rv2", 32'(redirect_valid), 32'd0);
      chk("t4_ws_pc", redirect_pc,         32'h8000_0102);
      chk("t4_ws_tc", 32'(taken_cnt),      32'd3);

      // exception on the PENDING handshake cycle
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0300);
      slot_fetched = 1'b1;
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      chk("t4_pd_rv", 32'(redirect_valid), 32'd1);
      chk("t4_pd_pc", redirect_pc,         32'h8000_0300);
      exc_flush = 1'b1;
      tick();
      exc_flush = 1'b0;
      chk("t4_hs_rv",  32'(redirect_valid), 32'd0);
      chk("t4_hs_rdy", 32'(res_ready),      32'd1);
      chk("t4_hs_fl",  32'(flush),          32'd0);
      chk("t4_hs_tc",  32'(taken_cnt),      32'd3);
      tick();
      chk("t4_hs_fl2", 32'(flush), 32'd0);

      // accepts coinciding with exc_flush are discarded
      exc_flush = 1'b1;
      beat(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0400);
      slot_fetched = 1'b1;
      tick();
      exc_flush = 1'b0;
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      chk("t4_ex_ntc", 32'(ntaken_cnt),     32'd3);
      chk("t4_ex_rv",  32'(redirect_valid), 32'd0);
      chk("t4_ex_rdy", 32'(res_ready),      32'd1);

      // asynchronous reset in the middle of PENDING
      fetch_ready = 1'b0;
      beat(1'b1, 1'b1, 1'b1, 32'h8000_0400);
      slot_fetched = 1'b1;
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      slot_fetched = 1'b0;
      chk("t5_rv", 32'(redirect_valid), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk_reset_vals("t5_async");
      #1 resetn = 1'b1;
      tick();

      // not-taken counter wraps 0xFFFF -> 0
      beat(1'b1, 1'b1, 1'b0, 32'h0);
      repeat (65535) tick();
      chk("t6_max", 32'(ntaken_cnt), 32'h0000_ffff);
      tick();
      beat(1'b0, 1'b0, 1'b0, 32'h0);
      chk("t6_wrap", 32'(ntaken_cnt), 32'd0);
      chk("t6_tc",   32'(taken_cnt),  32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
